pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised next-generation inter-stage pipeline register, usable for F/D, D/E, E/M and M/W boundaries.
- Carries NCH packed 32-bit-style fields (instr, pc, ext, alu, rd2, hilo, ...) across a valid/ready handshake.
- Adds flush, bubble injection and an optional 2-entry skid buffer, so backpressure no longer needs a global combinational stall path.

Parameters:
- W, 32, width of one channel in bits.
- NCH, 6, number of channels; the data bus is NCH*W bits, channel k at bits [k*W +: W].
- SKID, 1. 0 = single-register mode. 1 = two-entry skid buffer with registered in_ready.
- BUBBLE_VAL, 0, W-bit value driven on every channel of out_data while out_valid=0. 0 is the NOP encoding.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discard all held entries.
- in_valid  in  1  upstream stage presents a valid bundle.
- in_ready  out  1  this stage accepts a bundle this cycle.
- in_data  in  NCH*W  upstream bundle.
- out_valid  out  1  out_data holds a valid bundle.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  NCH*W  bundle to the next stage.
- occupancy  out  2  number of held entries: 0..1 when SKID=0, 0..2 when SKID=1.

Behaviour:
- Handshakes
  - Transfer in: in_valid & in_ready at a posedge.
  - Transfer out: out_valid & out_ready at a posedge.
  - Bundles leave in arrival order. None is duplicated or dropped, except by flush.
- Reset (rst=0, asynchronous)
  - out_valid=0, occupancy=0, all entries cleared.
  - out_data = BUBBLE_VAL on every channel.
  - in_ready=1 immediately while reset is asserted and after it releases.
  - Reset asserted mid-transfer aborts that transfer.
- SKID=0 mode
  - One register. in_ready = out_ready | ~out_valid (combinational).
  - Latency is 1 cycle: data accepted at edge N appears on out_data after edge N.
  - Simultaneous in and out transfer replaces the contents; full throughput.
- SKID=1 mode
  - Storage is a main register (drives out_data) plus a skid register.
  - in_ready is a flop: in_ready = ~(occupancy==2) as of the last edge. It has no combinational dependence on out_ready.
  - Empty + in transfer: data goes to main, occupancy becomes 1.
  - occupancy 1, in transfer and out transfer together: main takes in_data, occupancy stays 1.
  - occupancy 1, in transfer, no out transfer: in_data goes to skid, occupancy becomes 2, in_ready goes to 0.
  - occupancy 2 + out transfer: skid moves to main, occupancy becomes 1, in_ready goes to 1. No input is accepted that cycle because in_ready was 0.
  - Out transfer only, at occupancy 1: occupancy becomes 0.
  - Latency is 1 cycle when unstalled; sustained throughput is 1 bundle/cycle.
- Flush
  - Takes effect at the next posedge and overrides everything else: both entries invalidated, occupancy=0, out_valid=0, out_data=BUBBLE_VAL, in_ready=1.
  - A bundle offered in the flush cycle is dropped, even if in_ready=1.
  - An out transfer in the flush cycle still counts as consumed; downstream saw it.
- out_data is forced to BUBBLE_VAL whenever out_valid=0. Stale data is never visible.
- occupancy never exceeds 2, and never exceeds 1 when SKID=0. out_valid = (occupancy != 0).

Test Plan:
- Reset: assert rst=0 mid-stream with occupancy=2 -> out_valid=0, occupancy=0, out_data=all BUBBLE_VAL and in_ready=1 before the next clk edge.
- Streaming: SKID=1, NCH=6, out_ready=1, feed bundles with instr=0x0000_1000+i for i=0..7, one per cycle -> each bundle appears on out_data exactly 1 cycle later, in order, with no gaps.
- Backpressure: SKID=1, out_ready=0 while sending A=0xAAAA_0001 then B=0xBBBB_0002 -> occupancy=2, in_ready=0, out_data=A. Then out_ready=1 -> A, then B, leave in order. A third bundle C offered while in_ready=0 is not taken.
- Flush collision: occupancy=2, assert flush with in_valid=1 carrying 0xDEAD_BEEF -> next cycle occupancy=0, out_valid=0, out_data=0, and 0xDEAD_BEEF never appears on out_data.
- SKID=0: hold out_ready=0 with a held bundle -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 in the same cycle, and the replace-in-place transfer completes.
- Randomised ready/valid over 10k cycles, both SKID values -> scoreboard sees out_data sequence equal to the accepted in_data sequence, with flush-dropped entries excluded.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register with a valid/ready handshake,
// flush, bubble insertion on empty, and an optional two-entry skid buffer
// that registers in_ready so backpressure does not ripple combinationally.
module pipe_stage_buf #(
  parameter int          W          = 32,
  parameter int          NCH        = 6,
  parameter int          SKID       = 1,
  parameter logic [W-1:0] BUBBLE_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*W-1:0]   out_data,
  output logic [1:0]         occupancy
);

  localparam int DW = NCH * W;

  logic [DW-1:0] r_main;
  logic [1:0]    r_occ;
  logic [DW-1:0] w_bubble;
  logic          w_in_xfer;
  logic          w_out_xfer;

  assign w_bubble   = {NCH{BUBBLE_VAL}};
  assign out_valid  = (r_occ != 2'd0);
  assign out_data   = out_valid ? r_main : w_bubble;
  assign occupancy  = r_occ;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [DW-1:0] r_skid;
      logic          r_in_ready;
      logic [1:0]    w_occ_next;
      logic          w_load_main_in;
      logic          w_load_main_skid;
      logic          w_load_skid;

      assign in_ready = r_in_ready;

      // Next occupancy and which register loads, from the current fill level
      // and the two handshakes; flush wins over everything.
      always_comb begin
        w_occ_next       = r_occ;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
          w_occ_next = 2'd0;
        end else begin
          case (r_occ)
            2'd0: begin
              if (w_in_xfer) begin
                w_load_main_in = 1'b1;
                w_occ_next     = 2'd1;
              end
            end
            2'd1: begin
              if (w_in_xfer && w_out_xfer) begin
                w_load_main_in = 1'b1;
                w_occ_next     = 2'd1;
              end else if (w_in_xfer) begin
                w_load_skid = 1'b1;
                w_occ_next  = 2'd2;
              end else if (w_out_xfer) begin
                w_occ_next = 2'd0;
              end
            end
            2'd2: begin
              if (w_out_xfer) begin
                w_load_main_skid = 1'b1;
                w_occ_next       = 2'd1;
              end
            end
            default: begin
              w_occ_next = 2'd0;
            end
          endcase
        end
      end

      // Storage update; in_ready is registered from the next fill level so it
      // never depends combinationally on out_ready.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_main     <= '0;
          r_skid     <= '0;
          r_occ      <= 2'd0;
          r_in_ready <= 1'b1;
        end else begin
          r_occ      <= w_occ_next;
          r_in_ready <= (w_occ_next != 2'd2);
          if (w_load_main_in) begin
            r_main <= in_data;
          end else if (w_load_main_skid) begin
            r_main <= r_skid;
          end
          if (w_load_skid) begin
            r_skid <= in_data;
          end
        end
      end
    end else begin : g_single
      assign in_ready = out_ready | ~out_valid;

      // Single register: a new bundle replaces the held one whenever it is
      // accepted, which also covers the simultaneous in/out case.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_main <= '0;
          r_occ  <= 2'd0;
        end else if (flush) begin
          r_occ <= 2'd0;
        end else if (w_in_xfer) begin
          r_main <= in_data;
          r_occ  <= 2'd1;
        end else if (w_out_xfer) begin
          r_occ <= 2'd0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: drives a skid-buffer instance and a single-register
// instance side by side; a queue per instance holds the accepted bundles and
// a negedge monitor compares every visible output against the queue.
module tb_pipe_stage_buf;

  localparam int W  = 32;
  localparam int NCH = 6;
  localparam int DW = W * NCH;
  localparam logic [W-1:0] BUBBLE0 = 32'h0000_0013;

  logic clk;
  logic rst;

  logic          flush1, inValid1, inReady1, outValid1, outReady1;
  logic [DW-1:0] inData1, outData1;
  logic [1:0]    occ1;

  logic          flush0, inValid0, inReady0, outValid0, outReady0;
  logic [DW-1:0] inData0, outData0;
  logic [1:0]    occ0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];

  int checks;
  int errors;

  pipe_stage_buf #(.W(W), .NCH(NCH), .SKID(1), .BUBBLE_VAL(32'h0)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1),
    .out_valid(outValid1), .out_ready(outReady1), .out_data(outData1),
    .occupancy(occ1)
  );

  pipe_stage_buf #(.W(W), .NCH(NCH), .SKID(0), .BUBBLE_VAL(BUBBLE0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(inValid0), .in_ready(inReady0), .in_data(inData0),
    .out_valid(outValid0), .out_ready(outReady0), .out_data(outData0),
    .occupancy(occ0)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mkBundle(input logic [31:0] instr);
    logic [DW-1:0] b;
    for (int k = 0; k < NCH; k++) begin
      b[k*W +: W] = instr + 32'(k) * 32'h0101_0000;
    end
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus1(input logic v, input logic [31:0] instr, input logic ordy, input logic fl);
    inValid1  = v;
    inData1   = mkBundle(instr);
    outReady1 = ordy;
    flush1    = fl;
    tick();
  endtask

  task automatic applyStimulus0(input logic v, input logic [31:0] instr, input logic ordy, input logic fl);
    inValid0  = v;
    inData0   = mkBundle(instr);
    outReady0 = ordy;
    flush0    = fl;
    tick();
  endtask

  // Skid instance monitor: state vs model, head-of-queue data, then update
  // the model with this cycle's handshakes.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("occ1", DW'(occ1), DW'(q1.size()));
      checkOutput("inReady1", DW'(inReady1), DW'(q1.size() != 2));
      checkOutput("outValid1", DW'(outValid1), DW'(q1.size() != 0));
      if (q1.size() != 0) checkOutput("data1", outData1, q1[0]);
      else checkOutput("bubble1", outData1, '0);
      if (outValid1 && outReady1 && q1.size() != 0) void'(q1.pop_front());
      if (flush1) q1.delete();
      else if (inValid1 && inReady1) q1.push_back(inData1);
    end
  end

  // Single-register instance monitor, same structure with capacity one.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("occ0", DW'(occ0), DW'(q0.size()));
      checkOutput("inReady0", DW'(inReady0), DW'(outReady0 || q0.size() == 0));
      checkOutput("outValid0", DW'(outValid0), DW'(q0.size() != 0));
      if (q0.size() != 0) checkOutput("data0", outData0, q0[0]);
      else checkOutput("bubble0", outData0, {NCH{BUBBLE0}});
      if (outValid0 && outReady0 && q0.size() != 0) void'(q0.pop_front());
      if (flush0) q0.delete();
      else if (inValid0 && inReady0) q0.push_back(inData0);
    end
  end

  // Directed scenarios followed by a randomised run on both instances
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    flush1 = 0; inValid1 = 0; inData1 = '0; outReady1 = 0;
    flush0 = 0; inValid0 = 0; inData0 = '0; outReady0 = 0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) applyStimulus1(1'b1, 32'h0000_1000 + 32'(i), 1'b1, 1'b0);
    applyStimulus1(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus1(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] backpressure");
    applyStimulus1(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    applyStimulus1(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    checkOutput("bpOcc", DW'(occ1), DW'(2));
    checkOutput("bpInReady", DW'(inReady1), DW'(0));
    checkOutput("bpDataA", DW'(outData1[31:0]), DW'(32'hAAAA_0001));
    applyStimulus1(1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
    applyStimulus1(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bpDataB", DW'(outData1[31:0]), DW'(32'hBBBB_0002));
    applyStimulus1(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bpEmpty", DW'(occ1), DW'(0));

    $display("[TB] flush collision");
    applyStimulus1(1'b1, 32'h1111_0001, 1'b0, 1'b0);
    applyStimulus1(1'b1, 32'h2222_0002, 1'b0, 1'b0);
    applyStimulus1(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    checkOutput("flOcc", DW'(occ1), DW'(0));
    checkOutput("flValid", DW'(outValid1), DW'(0));
    checkOutput("flData", outData1, '0);
    checkOutput("flInReady", DW'(inReady1), DW'(1));
    applyStimulus1(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus1(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] single-register stall");
    applyStimulus0(1'b1, 32'h5555_0001, 1'b0, 1'b0);
    inValid0 = 1'b1;
    inData0  = mkBundle(32'h6666_0002);
    outReady0 = 1'b0;
    #1;
    checkOutput("s0Stall", DW'(inReady0), DW'(0));
    outReady0 = 1'b1;
    #1;
    checkOutput("s0Go", DW'(inReady0), DW'(1));
    tick();
    checkOutput("s0Replace", DW'(outData0[31:0]), DW'(32'h6666_0002));
    applyStimulus0(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("s0Empty", DW'(occ0), DW'(0));

    $display("[TB] reset mid-stream");
    applyStimulus1(1'b1, 32'h7777_0001, 1'b0, 1'b0);
    applyStimulus1(1'b1, 32'h8888_0002, 1'b0, 1'b0);
    applyStimulus0(1'b1, 32'h9999_0003, 1'b0, 1'b0);
    inValid1 = 0; inValid0 = 0;
    rst = 1'b0;
    #1;
    q1.delete();
    q0.delete();
    checkOutput("rstValid", DW'(outValid1), DW'(0));
    checkOutput("rstOcc", DW'(occ1), DW'(0));
    checkOutput("rstData", outData1, '0);
    checkOutput("rstInReady", DW'(inReady1), DW'(1));
    checkOutput("rstData0", outData0, {NCH{BUBBLE0}});
    tick(); tick();
    rst = 1'b1;
    tick();

    $display("[TB] random traffic");
    for (int c = 0; c < 10000; c++) begin
      inValid1  = 1'($urandom_range(0, 1));
      inData1   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      outReady1 = ($urandom_range(0, 9) < 6);
      flush1    = ($urandom_range(0, 99) < 2);
      inValid0  = 1'($urandom_range(0, 1));
      inData0   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      outReady0 = ($urandom_range(0, 9) < 6);
      flush0    = ($urandom_range(0, 99) < 2);
      tick();
    end
    inValid1 = 0; flush1 = 0; outReady1 = 1;
    inValid0 = 0; flush0 = 0; outReady0 = 1;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
